// File: rtl/hs_mem_spram_be_pkg.sv
`default_nettype none
// ============================================================================
// Module : hs_mem_spram_be_pkg
// Brief  : Shared types and helpers for the hs_mem single-port RAM family.
// Rev    : 1.0 - initial release
// ============================================================================
package hs_mem_spram_be_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rdw_mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } seq_state_e;

  function automatic int ceil_to_nxt_pow2(input int x);
    return 1 << $clog2(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hs_mem_spram_be_init_seq.sv
`default_nettype none
// ============================================================================
// Module : hs_mem_spram_be_init_seq
// Brief  : Clear sequencer; sweeps every array address once after reset/clr.
// Rev    : 1.0 - initial release
// ============================================================================
module hs_mem_spram_be_init_seq
  import hs_mem_spram_be_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ce,
  input  logic                  i_clr,
  output logic                  o_busy,
  output logic                  o_sweep_wen,
  output logic [ADDR_WIDTH-1:0] o_sweep_addr
);

  seq_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;

  // The array is a power of two, so the last address is all ones and the
  // counter naturally wraps back to zero when the sweep finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT_ON_RST ? ST_SWEEP : ST_IDLE;
      r_addr  <= '0;
    end else if (i_ce) begin
      case (r_state)
        ST_IDLE: begin
          if (i_clr) begin
            r_state <= ST_SWEEP;
            r_addr  <= '0;
          end
        end
        ST_SWEEP: begin
          if (&r_addr) begin
            r_state <= ST_IDLE;
          end
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state == ST_SWEEP);
  assign o_sweep_wen  = (r_state == ST_SWEEP);
  assign o_sweep_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/hs_mem_spram_be.sv
`default_nettype none
// ============================================================================
// Module : hs_mem_spram_be
// Brief  : Single-port RAM with byte enables, RDW modes, optional output reg
//          and a hardware clear sweep.
// Rev    : 1.0 - initial release
// ============================================================================
module hs_mem_spram_be
  import hs_mem_spram_be_pkg::*;
#(
  parameter  int                  DATA_WIDTH  = 32,
  parameter  int                  BYTE_WIDTH  = 8,
  parameter  int                  DATA_DEPTH  = 16,
  parameter  bit                  OUT_REG     = 1'b0,
  parameter  rdw_mode_e           RDW_MODE    = READ_FIRST,
  parameter  bit                  INIT_ON_RST = 1'b1,
  parameter  logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int                  c_addr_width = $clog2(DATA_DEPTH),
  localparam int                  c_num_bytes  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ce,
  input  logic                    req,
  input  logic                    wen,
  input  logic [c_addr_width-1:0] addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [c_num_bytes-1:0]  wbe,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  input  logic                    clr,
  output logic                    busy
);

  localparam int c_depth_real = ceil_to_nxt_pow2(DATA_DEPTH);

  logic [DATA_WIDTH-1:0]   r_mem [c_depth_real];
  logic [DATA_WIDTH-1:0]   r_s1_data;
  logic                    r_s1_valid;

  logic                    w_busy;
  logic                    w_sweep_wen;
  logic [c_addr_width-1:0] w_sweep_addr;
  logic                    w_sweep_we;
  logic                    w_acc;
  logic [c_addr_width-1:0] w_waddr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [c_num_bytes-1:0]  w_lane_we;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_s1_next;
  logic                    w_s1_upd;

  hs_mem_spram_be_init_seq #(
    .ADDR_WIDTH  (c_addr_width),
    .INIT_ON_RST (INIT_ON_RST)
  ) u_init_seq (
    .clk          (clk),
    .rst          (rst),
    .i_ce         (ce),
    .i_clr        (clr),
    .o_busy       (w_busy),
    .o_sweep_wen  (w_sweep_wen),
    .o_sweep_addr (w_sweep_addr)
  );

  // A clear request in the same cycle as an access wins; the access is dropped.
  assign w_acc      = ce && !rst && !w_busy && req && !clr;
  assign w_sweep_we = w_sweep_wen && !rst;

  assign w_waddr   = w_sweep_we ? w_sweep_addr : addr;
  assign w_wdata   = w_sweep_we ? INIT_VALUE : wdata;
  assign w_lane_we = w_sweep_we ? {c_num_bytes{1'b1}} :
                     ((w_acc && wen) ? wbe : '0);

  always_comb begin
    w_old    = r_mem[addr];
    w_merged = w_old;
    for (int i = 0; i < c_num_bytes; i++) begin
      if (wen && wbe[i]) begin
        w_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign w_s1_next = (RDW_MODE == WRITE_FIRST) ? w_merged : w_old;
  assign w_s1_upd  = w_acc && !((RDW_MODE == NO_CHANGE) && wen);

  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < c_num_bytes; i++) begin
        if (w_lane_we[i]) begin
          r_mem[w_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (rst) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else if (ce) begin
      r_s1_valid <= w_s1_upd;
      if (w_s1_upd) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_s2_data;
      logic                  r_s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_data  <= '0;
          r_s2_valid <= 1'b0;
        end else if (ce) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rdata  = r_s2_data;
      assign rvalid = r_s2_valid;
    end else begin : g_no_out_reg
      assign rdata  = r_s1_data;
      assign rvalid = r_s1_valid;
    end
  endgenerate

  assign busy = w_busy;

endmodule
`default_nettype wire
